// File: rtl/bcd_display_source.sv
// Data source for the 8-digit seven-segment driver: a debounced push-button and an
// optional periodic tick step an 8-digit BCD counter with leading-zero blanking.
module bcd_display_source #(
    parameter int DEB_CYCLES  = 2_000_000,
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_step,
    input  logic        run,
    input  logic        dir,
    output logic [31:0] output_data,
    output logic [7:0]  output_valid
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(TICK_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        HELD,
        CHK_REL
    } deb_state_t;

    function automatic logic [31:0] bcd_inc(input logic [31:0] v);
        logic [31:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] bcd_dec(input logic [31:0] v);
        logic [31:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A digit is lit when it or any more significant digit is nonzero; digit 0 always lit.
    function automatic logic [7:0] digit_mask(input logic [31:0] v);
        logic [7:0] m;
        logic       seen;
        m    = '0;
        seen = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            seen = seen | (v[4*i +: 4] != 4'd0);
            m[i] = seen;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    logic            btn_p0;
    logic            btn_p1;
    deb_state_t      state;
    deb_state_t      state_next;
    logic [DW-1:0]   deb_cnt;
    logic [DW-1:0]   deb_cnt_next;
    logic [DW-1:0]   deb_cnt_inc;
    logic            step_pulse;
    logic [TW-1:0]   tick_cnt;
    logic            tick_pulse;
    logic            ev_p0;
    logic [31:0]     data_next;
    logic [31:0]     data_p1;
    logic [7:0]      mask_p1;

    // Stage p0/p1: two-flop synchronizer for the asynchronous pad
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_p0 <= 1'b0;
            btn_p1 <= 1'b0;
        end else begin
            btn_p0 <= btn_step;
            btn_p1 <= btn_p0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            state   <= state_next;
            deb_cnt <= deb_cnt_next;
        end
    end

    assign deb_cnt_inc = deb_cnt + DW'(1);

    always_comb begin
        state_next   = state;
        deb_cnt_next = deb_cnt;
        step_pulse   = 1'b0;
        case (state)
            IDLE: begin
                if (btn_p1) begin
                    state_next   = CHK_PRESS;
                    deb_cnt_next = '0;
                end
            end
            CHK_PRESS: begin
                if (!btn_p1) begin
                    state_next = IDLE;
                end else begin
                    deb_cnt_next = deb_cnt_inc;
                    if (deb_cnt_inc == DEB_LAST) begin
                        state_next = HELD;
                        step_pulse = 1'b1;
                    end
                end
            end
            HELD: begin
                if (!btn_p1) begin
                    state_next   = CHK_REL;
                    deb_cnt_next = '0;
                end
            end
            CHK_REL: begin
                if (btn_p1) begin
                    state_next = HELD;
                end else begin
                    deb_cnt_next = deb_cnt_inc;
                    if (deb_cnt_inc == DEB_LAST) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                deb_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (!run || tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick_pulse = run && (tick_cnt == TICK_LAST);

    // Stage p0: coincident press and tick collapse into a single step
    assign ev_p0     = step_pulse | tick_pulse;
    assign data_next = dir ? bcd_dec(data_p1) : bcd_inc(data_p1);

    // Stage p1: value and digit mask registered together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1 <= 32'h0;
            mask_p1 <= 8'h01;
        end else if (ev_p0) begin
            data_p1 <= data_next;
            mask_p1 <= digit_mask(data_next);
        end
    end

    assign output_data  = data_p1;
    assign output_valid = mask_p1;

endmodule

// File: tb/tb_bcd_display_source.sv
// Randomized and directed bench for bcd_display_source; an integer-valued reference
// model built from run-lengths of the synchronized button and of run tracks the DUT.
module tb_bcd_display_source;

    localparam int DEB  = 4;
    localparam int TICK = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_step = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic [31:0] output_data;
    logic [7:0]  output_valid;

    int checks = 0;
    int errors = 0;

    int m_val;
    int m_hi;
    int m_lo;
    int m_run_len;
    bit m_armed;
    bit m_s1;
    bit m_s2;

    bcd_display_source #(
        .DEB_CYCLES (DEB),
        .TICK_CYCLES(TICK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_step    (btn_step),
        .run         (run),
        .dir         (dir),
        .output_data (output_data),
        .output_valid(output_valid)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int          t;
        r = '0;
        t = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_mask(input int v);
        logic [7:0] m;
        int         p;
        m = '0;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 0 || v >= p) m[i] = 1'b1;
            p = p * 10;
        end
        return m;
    endfunction

    task automatic model_reset();
        m_val     = 0;
        m_hi      = 0;
        m_lo      = 0;
        m_run_len = 0;
        m_armed   = 1'b1;
        m_s1      = 1'b0;
        m_s2      = 1'b0;
    endtask

    // One clock of the reference: a press counts once the synchronized button has been
    // high for DEB cycles; it re-arms after DEB consecutive low cycles.
    task automatic model_cycle();
        bit bs;
        bit step;
        bit tick;
        if (rst) begin
            model_reset();
        end else begin
            bs   = m_s2;
            step = 1'b0;
            if (bs) begin
                m_hi++;
                m_lo = 0;
            end else begin
                m_lo++;
                m_hi = 0;
            end
            if (m_armed && bs && m_hi == DEB) begin
                step    = 1'b1;
                m_armed = 1'b0;
            end else if (!m_armed && !bs && m_lo == DEB) begin
                m_armed = 1'b1;
            end
            tick = 1'b0;
            if (run) begin
                m_run_len++;
                tick = (m_run_len % TICK) == 0;
            end else begin
                m_run_len = 0;
            end
            if (step || tick)
                m_val = dir ? (m_val + 99_999_999) % 100_000_000 : (m_val + 1) % 100_000_000;
            m_s2 = m_s1;
            m_s1 = btn_step;
        end
    endtask

    task automatic tick_clk();
        @(posedge clk);
        model_cycle();
        #1;
        check_val("data", output_data, to_bcd(m_val));
        check_val("valid", {24'h0, output_valid}, {24'h0, exp_mask(m_val)});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick_clk();
    endtask

    task automatic press(input int hold, input int rel);
        btn_step = 1'b1;
        cycles(hold);
        btn_step = 1'b0;
        cycles(rel);
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        #1;
        check_val("rst0_data", output_data, 32'h0);
        check_val("rst0_valid", {24'h0, output_valid}, 32'h01);
        cycles(2);
        rst = 1'b0;
        cycles(3);

        // Bounces shorter than the debounce window, then a solid hold
        press(1, 1);
        press(2, 1);
        press(1, 2);
        press(20, 12);
        check_val("deb_data", output_data, 32'h00000001);
        check_val("deb_valid", {24'h0, output_valid}, 32'h01);

        dir = 1'b1;
        press(8, 10);
        check_val("dn_from1_data", output_data, 32'h00000000);
        press(8, 10);
        check_val("wrap_dn_data", output_data, 32'h99999999);
        check_val("wrap_dn_valid", {24'h0, output_valid}, 32'hFF);
        dir = 1'b0;
        press(8, 10);
        check_val("wrap_up_data", output_data, 32'h00000000);
        check_val("wrap_up_valid", {24'h0, output_valid}, 32'h01);

        // Preload 999 with ticks
        run = 1'b1;
        cycles(999 * TICK);
        run = 1'b0;
        check_val("preload_data", output_data, 32'h00000999);
        check_val("preload_valid", {24'h0, output_valid}, 32'h07);
        press(8, 10);
        check_val("carry_data", output_data, 32'h00001000);
        check_val("carry_valid", {24'h0, output_valid}, 32'h0F);
        dir = 1'b1;
        press(8, 10);
        check_val("borrow_data", output_data, 32'h00000999);
        check_val("borrow_valid", {24'h0, output_valid}, 32'h07);
        dir = 1'b0;

        // Press pulse lands in the same cycle as the first tick after run rises
        run = 1'b1;
        cycles(2);
        btn_step = 1'b1;
        cycles(6);
        run = 1'b0;
        cycles(4);
        btn_step = 1'b0;
        cycles(10);
        check_val("collide_data", output_data, 32'h00001000);

        run = 1'b1;
        cycles(80);
        run = 1'b0;
        check_val("run80_data", output_data, 32'h00001010);
        check_val("run80_valid", {24'h0, output_valid}, 32'h0F);

        // Dropping run mid-period restarts the divider
        run = 1'b1;
        cycles(5);
        run = 1'b0;
        cycles(3);
        run = 1'b1;
        cycles(7);
        check_val("restart_hold", output_data, 32'h00001010);
        cycles(1);
        run = 1'b0;
        check_val("restart_tick", output_data, 32'h00001011);

        for (int s = 0; s < 80; s++) begin
            btn_step = 1'($urandom_range(0, 1));
            run      = ($urandom_range(0, 3) == 0);
            dir      = 1'($urandom_range(0, 1));
            cycles(int'($urandom_range(1, 10)));
        end
        btn_step = 1'b0;
        run      = 1'b0;
        dir      = 1'b0;
        cycles(10);
        press(8, 10);

        // Asynchronous reset mid-press while running
        btn_step = 1'b1;
        run      = 1'b1;
        cycles(3);
        #2 rst = 1'b1;
        #1;
        check_val("rst_async_data", output_data, 32'h0);
        check_val("rst_async_valid", {24'h0, output_valid}, 32'h01);
        run = 1'b0;
        cycles(2);
        rst = 1'b0;
        cycles(5);
        check_val("rst_held_nopulse", output_data, 32'h0);
        cycles(1);
        check_val("rst_held_pulse", output_data, 32'h00000001);
        btn_step = 1'b0;
        cycles(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
